// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller: load-use and mult/div interlocks,
// branch flushes, data-memory wait hold with a sticky timeout, and a stall counter.
module hazard_stall_ctrl #(
   parameter int MULDIV_LAT  = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_ex_mem_read,
   input  logic [4:0]  id_ex_rt,
   input  logic [4:0]  if_id_rs,
   input  logic [4:0]  if_id_rt,
   input  logic        if_id_uses_rt,
   input  logic        id_muldiv,
   input  logic        id_hilo_read,
   input  logic        ex_branch_taken,
   input  logic        mem_wait,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        control_mux_sel,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        pipe_hold,
   output logic        muldiv_busy,
   output logic        mem_timeout,
   output logic [15:0] stall_count,
   output logic [1:0]  mode_dbg
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } mode_t;

   mode_t       mode;
   mode_t       mode_next;
   logic [3:0]  md_cnt;
   logic [3:0]  md_next;
   logic [7:0]  w_cnt;
   logic [7:0]  w_next;
   logic [7:0]  w_inc;
   logic [15:0] sc_next;

   logic load_use;
   logic md_hz;
   logic hold;
   logic flush;
   logic stall;
   logic issue;

   // Register 0 is hardwired, so a load targeting it can never create a hazard.
   always_comb begin
      load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
      md_hz    = muldiv_busy && (id_muldiv || id_hilo_read);
      hold     = (mode == TIMEOUT) || mem_wait;
      flush    = ex_branch_taken;
      stall    = md_hz || load_use;
   end

   always_comb begin
      muldiv_busy = (md_cnt != 4'd0);
      mem_timeout = (mode == TIMEOUT);
      mode_dbg    = mode;
   end

   // Priority: hold > flush > stall > normal; reset forces a plain normal pattern.
   always_comb begin
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      control_mux_sel = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      pipe_hold       = 1'b0;
      issue           = 1'b0;
      if (reset) begin
         issue = 1'b0;
      end else if (hold) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (flush) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (stall) begin
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
         control_mux_sel = 1'b1;
      end else begin
         issue = id_muldiv;
      end
   end

   // A timeout is declared on the same edge the wait count reaches the limit.
   always_comb begin
      mode_next = mode;
      w_inc     = (w_cnt == 8'hFF) ? 8'hFF : w_cnt + 8'd1;
      w_next    = w_cnt;
      if (mem_wait) begin
         w_next = w_inc;
      end else if (mode != TIMEOUT) begin
         w_next = 8'd0;
      end
      case (mode)
         RUN: begin
            if (mem_wait) begin
               mode_next = (w_inc >= 8'(MEM_TIMEOUT)) ? TIMEOUT : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (!mem_wait) begin
               mode_next = RUN;
            end else if (w_inc >= 8'(MEM_TIMEOUT)) begin
               mode_next = TIMEOUT;
            end
         end
         TIMEOUT:  mode_next = TIMEOUT;
         default:  mode_next = RUN;
      endcase
   end

   always_comb begin
      md_next = md_cnt;
      if (issue) begin
         md_next = 4'(MULDIV_LAT);
      end else if (md_cnt != 4'd0) begin
         md_next = md_cnt - 4'd1;
      end
      sc_next = stall_count;
      if (!pc_write && (stall_count != 16'hFFFF)) begin
         sc_next = stall_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode        <= RUN;
         md_cnt      <= 4'd0;
         w_cnt       <= 8'd0;
         stall_count <= 16'd0;
      end else begin
         mode        <= mode_next;
         md_cnt      <= md_next;
         w_cnt       <= w_next;
         stall_count <= sc_next;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a behavioural model predicts every cycle's outputs
// into a queue that a negedge monitor drains against the DUT.
module tb_hazard_stall_ctrl;

   localparam int LAT = 4;
   localparam int TMO = 255;

   logic        clk;
   logic        reset;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rt;
   logic [4:0]  if_id_rs;
   logic [4:0]  if_id_rt;
   logic        if_id_uses_rt;
   logic        id_muldiv;
   logic        id_hilo_read;
   logic        ex_branch_taken;
   logic        mem_wait;
   logic        pc_write;
   logic        if_id_write;
   logic        control_mux_sel;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        pipe_hold;
   logic        muldiv_busy;
   logic        mem_timeout;
   logic [15:0] stall_count;
   logic [1:0]  mode_dbg;

   hazard_stall_ctrl #(.MULDIV_LAT(LAT), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
      .id_muldiv(id_muldiv), .id_hilo_read(id_hilo_read),
      .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .control_mux_sel(control_mux_sel), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold),
      .muldiv_busy(muldiv_busy), .mem_timeout(mem_timeout),
      .stall_count(stall_count), .mode_dbg(mode_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_errors = 0;
   string cur_tag  = "init";

   logic [25:0] exp_q[$];

   // model state
   int          m_mode;
   int          m_md;
   int          m_w;
   int          m_sc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // scoreboard monitor: {pc,ifid,cms,iff,idf,hold,busy,tmo,stall_count,mode}
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [25:0] e;
         e = exp_q.pop_front();
         check(cur_tag, {6'd0, pc_write, if_id_write, control_mux_sel, if_id_flush,
                         id_ex_flush, pipe_hold, muldiv_busy, mem_timeout,
                         stall_count, mode_dbg}, {6'd0, e});
      end
   end

   // driver: apply one cycle of inputs, predict outputs, advance the model
   task automatic step(input logic rst, input logic mw, input logic br, input logic rd,
                       input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic md, input logic hilo);
      logic [5:0] ctrl;
      logic       lu;
      logic       busy;
      logic       hz;
      int         nw;
      reset = rst; mem_wait = mw; ex_branch_taken = br; id_ex_mem_read = rd;
      id_ex_rt = ex_rt; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
      id_muldiv = md; id_hilo_read = hilo;
      lu   = rd && (ex_rt != 5'd0) && ((ex_rt == rs) || (urt && (ex_rt == rt)));
      busy = (m_md != 0);
      hz   = busy && (md || hilo);
      if (rst)                       ctrl = 6'b110000;
      else if (m_mode == 2 || mw)    ctrl = 6'b000001;
      else if (br)                   ctrl = 6'b110110;
      else if (hz || lu)             ctrl = 6'b001000;
      else                           ctrl = 6'b110000;
      exp_q.push_back({ctrl, busy, (m_mode == 2), m_sc[15:0], m_mode[1:0]});
      @(posedge clk);
      #1;
      if (rst) begin
         m_mode = 0; m_md = 0; m_w = 0; m_sc = 0;
      end else begin
         if (ctrl == 6'b110000 && md)  m_md = LAT;
         else if (m_md > 0)            m_md = m_md - 1;
         nw = mw ? ((m_w < 255) ? m_w + 1 : 255) : ((m_mode == 2) ? m_w : 0);
         if (m_mode != 2) m_mode = mw ? ((nw >= TMO) ? 2 : 1) : 0;
         m_w = nw;
         if (!ctrl[5] && m_sc < 16'hFFFF) m_sc = m_sc + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   initial begin
      int base;
      reset = 1'b1; mem_wait = 0; ex_branch_taken = 0; id_ex_mem_read = 0;
      id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0; if_id_uses_rt = 0;
      id_muldiv = 0; id_hilo_read = 0;
      m_mode = 0; m_md = 0; m_w = 0; m_sc = 0;
      repeat (2) @(posedge clk);
      #1;

      cur_tag = "reset_hold";
      step(1, 1, 1, 1, 5'd8, 5'd8, 5'd8, 1, 1, 1);
      check("reset_state", {16'd0, stall_count}, 32'd0);

      cur_tag = "load_use";
      step(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
      step(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
      step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      check("lu_count", {16'd0, stall_count}, 32'd2);

      cur_tag = "uses_rt";
      step(0, 0, 0, 1, 5'd30, 5'd4, 5'd30, 0, 0, 0);
      step(0, 0, 0, 1, 5'd30, 5'd4, 5'd30, 1, 0, 0);
      check("rt_count", {16'd0, stall_count}, 32'd3);

      cur_tag = "muldiv";
      base = 3;
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      check("md_busy_issue", {31'd0, muldiv_busy}, 32'd1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      check("md_stall4", {16'd0, stall_count}, base + 4);
      check("md_idle", {31'd0, muldiv_busy}, 32'd0);

      cur_tag = "branch_wins";
      step(0, 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
      check("br_no_count", {16'd0, stall_count}, base + 4);

      cur_tag = "random";
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
      end

      cur_tag = "timeout";
      step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      for (int i = 0; i < 255; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("tmo_set", {31'd0, mem_timeout}, 32'd1);
      step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
      check("tmo_count", {16'd0, stall_count}, 32'd257);
      step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("tmo_cleared", {31'd0, mem_timeout}, 32'd0);

      cur_tag = "reset_mid_md";
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("pre_rst_sc", {16'd0, stall_count}, 32'd10);
      check("pre_rst_busy", {31'd0, muldiv_busy}, 32'd1);
      step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      check("rst_busy", {31'd0, muldiv_busy}, 32'd0);
      check("rst_sc", {16'd0, stall_count}, 32'd0);
      check("rst_mode", {30'd0, mode_dbg}, 32'd0);
      idle(3);

      repeat (3) @(negedge clk);
      check("drain", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
